// File: rtl/comparator_search_8_bit.sv
// Binary-search initiator for an 8-bit magnitude comparator: probes the B operand and recovers A.
// Optional probe counter output enabled by defining COMPARATOR_SEARCH_PROBE_COUNT_EN.
module comparator_search_8_bit #(
    parameter int DATA_WIDTH   = 8,
    parameter int COMPARE_WAIT = 0
) (
    input  logic                  Clock_In,
    input  logic                  Reset_In,
    input  logic                  Start_In,
    output logic [DATA_WIDTH-1:0] Probe_Out,
    output logic                  Probe_Valid_Out,
    input  logic                  A_Less_Than_B_In,
    input  logic                  A_Equal_To_B_In,
    input  logic                  A_Greater_Than_B_In,
    output logic                  Busy_Out,
    output logic                  Done_Out,
    output logic                  Found_Out,
    output logic                  Error_Out,
`ifdef COMPARATOR_SEARCH_PROBE_COUNT_EN
    output logic [$clog2(DATA_WIDTH+2)-1:0] Probe_Count_Out,
`endif
    output logic [DATA_WIDTH-1:0] Result_Out
);

    localparam int SW = (COMPARE_WAIT > 0) ? $clog2(COMPARE_WAIT + 1) : 1;
    localparam logic [SW-1:0]       WAIT_LAST = SW'(COMPARE_WAIT);
    localparam logic [DATA_WIDTH:0] ONE_W     = (DATA_WIDTH+1)'(1);
    localparam logic [DATA_WIDTH:0] TOP_W     = {1'b0, {DATA_WIDTH{1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                state_r, state_s;
    logic [DATA_WIDTH-1:0] probe_r, probe_s;
    logic [DATA_WIDTH-1:0] result_r, result_s;
    logic                  valid_r, valid_s;
    logic                  busy_r, busy_s;
    logic                  done_r, done_s;
    logic                  found_r, found_s;
    logic                  error_r, error_s;
    logic [DATA_WIDTH:0]   low_r, low_s;
    logic [DATA_WIDTH:0]   high_r, high_s;
    logic [DATA_WIDTH:0]   new_low_s, new_high_s;
    logic [SW-1:0]         settle_r, settle_s;
    logic [2:0]            flags_s;
    logic                  launch_s;
    logic                  finish_s;
`ifdef COMPARATOR_SEARCH_PROBE_COUNT_EN
    logic [$clog2(DATA_WIDTH+2)-1:0] cnt_r, cnt_s;
`endif

    function automatic logic [DATA_WIDTH-1:0] mid_of(input logic [DATA_WIDTH:0] lo,
                                                     input logic [DATA_WIDTH:0] hi);
        return DATA_WIDTH'((lo + hi) >> 1);
    endfunction

    // Next-state and next-output logic for the search sequencer.
    always_comb begin
        state_s    = state_r;
        probe_s    = probe_r;
        result_s   = result_r;
        valid_s    = valid_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        found_s    = found_r;
        error_s    = error_r;
        low_s      = low_r;
        high_s     = high_r;
        settle_s   = settle_r;
        new_low_s  = low_r;
        new_high_s = high_r;
        launch_s   = 1'b0;
        finish_s   = 1'b0;
        flags_s    = {A_Less_Than_B_In, A_Equal_To_B_In, A_Greater_Than_B_In};
`ifdef COMPARATOR_SEARCH_PROBE_COUNT_EN
        cnt_s      = cnt_r;
`endif
        case (state_r)
            ST_IDLE: begin
                launch_s = Start_In;
            end
            ST_PROBE: begin
                if (settle_r == WAIT_LAST) begin
`ifdef COMPARATOR_SEARCH_PROBE_COUNT_EN
                    cnt_s = cnt_r + 1'b1;
`endif
                    case (flags_s)
                        3'b010: begin
                            found_s  = 1'b1;
                            finish_s = 1'b1;
                        end
                        3'b001: new_low_s  = {1'b0, probe_r} + ONE_W;
                        3'b100: new_high_s = {1'b0, probe_r} - ONE_W;
                        default: begin
                            error_s  = 1'b1;
                            found_s  = 1'b0;
                            finish_s = 1'b1;
                        end
                    endcase
                    // High's extra MSB flags an underflow below zero (Less on probe 0).
                    if (!finish_s && (new_high_s[DATA_WIDTH] || (new_low_s > new_high_s))) begin
                        error_s  = 1'b1;
                        finish_s = 1'b1;
                        result_s = probe_r;
                    end else if (!finish_s) begin
                        low_s    = new_low_s;
                        high_s   = new_high_s;
                        probe_s  = mid_of(new_low_s, new_high_s);
                        settle_s = '0;
                    end else begin
                        result_s = probe_r;
                    end
                end else begin
                    settle_s = settle_r + 1'b1;
                end
            end
            ST_DONE: begin
                state_s  = ST_IDLE;
                launch_s = Start_In;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if (launch_s) begin
            state_s  = ST_PROBE;
            low_s    = '0;
            high_s   = TOP_W;
            probe_s  = mid_of('0, TOP_W);
            valid_s  = 1'b1;
            busy_s   = 1'b1;
            found_s  = 1'b0;
            error_s  = 1'b0;
            settle_s = '0;
`ifdef COMPARATOR_SEARCH_PROBE_COUNT_EN
            cnt_s    = '0;
`endif
        end else if (finish_s) begin
            state_s = ST_DONE;
            done_s  = 1'b1;
            busy_s  = 1'b0;
            valid_s = 1'b0;
        end else begin
            done_s = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            state_r  <= ST_IDLE;
            probe_r  <= '0;
            result_r <= '0;
            valid_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            found_r  <= 1'b0;
            error_r  <= 1'b0;
            low_r    <= '0;
            high_r   <= '0;
            settle_r <= '0;
`ifdef COMPARATOR_SEARCH_PROBE_COUNT_EN
            cnt_r    <= '0;
`endif
        end else begin
            state_r  <= state_s;
            probe_r  <= probe_s;
            result_r <= result_s;
            valid_r  <= valid_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
            found_r  <= found_s;
            error_r  <= error_s;
            low_r    <= low_s;
            high_r   <= high_s;
            settle_r <= settle_s;
`ifdef COMPARATOR_SEARCH_PROBE_COUNT_EN
            cnt_r    <= cnt_s;
`endif
        end
    end

    assign Probe_Out       = probe_r;
    assign Probe_Valid_Out = valid_r;
    assign Busy_Out        = busy_r;
    assign Done_Out        = done_r;
    assign Found_Out       = found_r;
    assign Error_Out       = error_r;
    assign Result_Out      = result_r;
`ifdef COMPARATOR_SEARCH_PROBE_COUNT_EN
    assign Probe_Count_Out = cnt_r;
`endif

endmodule

// File: tb/tb_comparator_search_8_bit.sv
// Self-checking bench for comparator_search_8_bit: vector table, corner sequences, random A values.
module tb_comparator_search_8_bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start2;
    logic [7:0] a0, a2;
    int         force_mode;

    logic [7:0] p0, res0, p2, res2;
    logic       pv0, busy0, done0, found0, err0, lt0, eq0, gt0;
    logic       pv2, busy2, done2, found2, err2, lt2, eq2, gt2;
`ifdef COMPARATOR_SEARCH_PROBE_COUNT_EN
    logic [3:0] cnt0, cnt2;
`endif

    always #5 clk = ~clk;

    // Reference comparator for the W=0 unit, with fault forcing.
    always_comb begin
        lt0 = (a0 < p0);
        eq0 = (a0 == p0);
        gt0 = (a0 > p0);
        case (force_mode)
            1: begin lt0 = 1'b0; eq0 = 1'b0; gt0 = 1'b0; end
            2: begin lt0 = 1'b1; eq0 = 1'b0; gt0 = 1'b0; end
            default: ;
        endcase
    end

    assign lt2 = (a2 < p2);
    assign eq2 = (a2 == p2);
    assign gt2 = (a2 > p2);

    comparator_search_8_bit #(.DATA_WIDTH(8), .COMPARE_WAIT(0)) dut0 (
        .Clock_In(clk), .Reset_In(rst), .Start_In(start0),
        .Probe_Out(p0), .Probe_Valid_Out(pv0),
        .A_Less_Than_B_In(lt0), .A_Equal_To_B_In(eq0), .A_Greater_Than_B_In(gt0),
        .Busy_Out(busy0), .Done_Out(done0), .Found_Out(found0), .Error_Out(err0),
`ifdef COMPARATOR_SEARCH_PROBE_COUNT_EN
        .Probe_Count_Out(cnt0),
`endif
        .Result_Out(res0));

    comparator_search_8_bit #(.DATA_WIDTH(8), .COMPARE_WAIT(2)) dut2 (
        .Clock_In(clk), .Reset_In(rst), .Start_In(start2),
        .Probe_Out(p2), .Probe_Valid_Out(pv2),
        .A_Less_Than_B_In(lt2), .A_Equal_To_B_In(eq2), .A_Greater_Than_B_In(gt2),
        .Busy_Out(busy2), .Done_Out(done2), .Found_Out(found2), .Error_Out(err2),
`ifdef COMPARATOR_SEARCH_PROBE_COUNT_EN
        .Probe_Count_Out(cnt2),
`endif
        .Result_Out(res2));

    int total = 0;
    int bad   = 0;
    int exp_q[$];
    logic [7:0] got_q[$];
    int  model_n;
    bit  model_found;
    int  edges;

    typedef struct {
        logic [7:0] a;
        bit         found;
        logic [7:0] result;
        int         probes;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Plain integer binary search over 0..255.
    task automatic model_search(input logic [7:0] a);
        int lo, hi, mid;
        lo = 0; hi = 255;
        model_n = 0; model_found = 1'b0;
        exp_q.delete();
        while (1) begin
            mid = (lo + hi) / 2;
            exp_q.push_back(mid);
            model_n++;
            if (int'(a) == mid) begin
                model_found = 1'b1;
                break;
            end
            if (int'(a) > mid) lo = mid + 1;
            else hi = mid - 1;
            if (lo > hi) break;
        end
    endtask

    // Runs one search on the W=0 unit; returns at the Done cycle (or timeout).
    task automatic run0(input logic [7:0] a, input int glitch_at);
        a0 = a;
        got_q.delete();
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        edges = 1;
        if (pv0) got_q.push_back(p0);
        for (int i = 0; i < 100; i++) begin
            start0 = (i == glitch_at);
            @(posedge clk); #1;
            edges++;
            if (done0) break;
            if (pv0) got_q.push_back(p0);
        end
        start0 = 1'b0;
        check("done_reached", done0, 1);
    endtask

    task automatic check_seq(input string name);
        bit ok;
        ok = (got_q.size() == exp_q.size());
        for (int i = 0; i < got_q.size() && ok; i++)
            if (got_q[i] != exp_q[i][7:0]) ok = 1'b0;
        check(name, ok, 1);
    endtask

    initial begin
        bit done_seen;
        bit stable;
        int k;
        logic [7:0] cur;

        vecs[0] = '{8'h7F, 1'b1, 8'h7F, 1};
        vecs[1] = '{8'h00, 1'b1, 8'h00, 8};
        vecs[2] = '{8'hFF, 1'b1, 8'hFF, 9};
        vecs[3] = '{8'h01, 1'b1, 8'h01, 7};
        vecs[4] = '{8'h80, 1'b1, 8'h80, 8};

        rst = 1'b1; start0 = 1'b0; start2 = 1'b0; a0 = 8'h00; a2 = 8'h00; force_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_probe", p0, 0);
        check("rst_valid", pv0, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_found", found0, 0);
        check("rst_result", res0, 0);
        check("rst_busy2", busy2, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            model_search(vecs[v].a);
            run0(vecs[v].a, -1);
            check("vec_found", found0, vecs[v].found);
            check("vec_error", err0, 0);
            check("vec_result", res0, vecs[v].result);
            check("vec_probes", got_q.size(), vecs[v].probes);
            check("vec_latency", edges, vecs[v].probes + 1);
            check("vec_busy_done", {busy0, pv0}, 2'b00);
            check_seq("vec_seq");
`ifdef COMPARATOR_SEARCH_PROBE_COUNT_EN
            check("vec_count", cnt0, vecs[v].probes);
`endif
            @(posedge clk); #1;
            check("vec_done_pulse", done0, 0);
            check("vec_found_hold", found0, vecs[v].found);
        end

        // Reset during the third probe.
        a0 = 8'h00;
        @(negedge clk); start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_mid_probe3", p0, 8'h1F);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("rstm_probe", p0, 0);
        check("rstm_flags", {pv0, busy0, done0, found0, err0}, 5'b0);
        check("rstm_result", res0, 0);
        @(negedge clk); rst = 1'b0;
        done_seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done0 || busy0) done_seen = 1'b1;
        end
        check("rstm_no_done", done_seen, 0);

        // Flags all clear on first probe.
        force_mode = 1;
        run0(8'h55, -1);
        check("f0_error", err0, 1);
        check("f0_found", found0, 0);
        check("f0_result", res0, 8'h7F);
        check("f0_probes", got_q.size(), 1);
        check("f0_latency", edges, 2);
`ifdef COMPARATOR_SEARCH_PROBE_COUNT_EN
        check("f0_count", cnt0, 1);
`endif
        // Less on every probe exhausts the range at probe 0.
        force_mode = 2;
        run0(8'h55, -1);
        check("fl_error", err0, 1);
        check("fl_found", found0, 0);
        check("fl_probes", got_q.size(), 8);
        check("fl_last", (got_q.size() > 0) ? got_q[got_q.size()-1] : 8'hEE, 8'h00);
        check("fl_latency", edges, 9);
`ifdef COMPARATOR_SEARCH_PROBE_COUNT_EN
        check("fl_count", cnt0, 8);
`endif
        force_mode = 0;
        @(posedge clk);

        // Start pulsed mid-search must be ignored.
        model_search(8'h00);
        run0(8'h00, 2);
        check("ign_found", found0, 1);
        check("ign_probes", got_q.size(), 8);
        check_seq("ign_seq");

        // Start held in DONE restarts immediately.
        run0(8'h7F, -1);
        check("b2b_first_found", found0, 1);
        start0 = 1'b1; a0 = 8'hC0;
        @(posedge clk); #1;
        start0 = 1'b0;
        check("b2b_probe", p0, 8'h7F);
        check("b2b_busy_valid_done", {busy0, pv0, done0}, 3'b110);
        check("b2b_found_clear", found0, 0);
        for (int i = 0; i < 50 && !done0; i++) begin
            @(posedge clk); #1;
        end
        check("b2b_done", done0, 1);
        check("b2b_found", found0, 1);
        check("b2b_result", res0, 8'hC0);

        // Settle cycles: A is wrong except on the sampling cycle.
        model_search(8'hA5);
        a2 = 8'h00;
        @(negedge clk); start2 = 1'b1;
        @(posedge clk); #1; start2 = 1'b0;
        edges = 1; k = 0; stable = 1'b1; cur = p2;
        for (int i = 0; i < 100; i++) begin
            a2 = (k < 2) ? 8'h00 : 8'hA5;
            @(posedge clk); #1;
            edges++;
            if (done2) break;
            k = (k + 1) % 3;
            if (k != 0 && p2 != cur) stable = 1'b0;
            cur = p2;
        end
        check("w2_done", done2, 1);
        check("w2_found", found2, 1);
        check("w2_result", res2, 8'hA5);
        check("w2_latency", edges, model_n * 3 + 1);
        check("w2_stable", stable, 1);

        // Random A values against the integer model.
        for (int r = 0; r < 20; r++) begin
            cur = 8'($urandom_range(0, 255));
            model_search(cur);
            run0(cur, -1);
            check("rnd_found", found0, model_found);
            check("rnd_result", res0, cur);
            check("rnd_latency", edges, model_n + 1);
            check_seq("rnd_seq");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
